wb_line_master: RTL and testbench
=================================

# wb_line_master

Pipelined Wishbone B4 master that moves one whole cache line per request between the cache controller and the `wb_mem` backing store. A line request is either a refill read or a writeback write, and it is split into `LINE_WORDS` single-word bus beats. The block issues beats back-to-back while the slave does not stall, collects the acks in order, assembles the refill line, and returns one response per request. It sits directly upstream of `wb_mem` in the pipelined-plus-cache memory path.

## Interface
Parameters:
- `WB_AW`, 12: word address width.
- `WB_DW`, 32: data width. `WB_SL` = `WB_DW`/8.
- `LINE_WORDS`, 4: words per line. Power of two, at least 2.
- `TIMEOUT`, 255: watchdog limit in cycles. Used only with `WB_TIMEOUT_EN`.

Ports:
- `clk_i`, in, 1: clock. Single clock domain.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `req_valid_i`, in, 1: line request valid.
- `req_ready_o`, out, 1: master idle, can accept a request.
- `req_we_i`, in, 1: 1 = writeback, 0 = refill.
- `req_adr_i`, in, `WB_AW`: line base word address. The low log2(`LINE_WORDS`) bits are forced to 0.
- `req_wdata_i`, in, `LINE_WORDS`*`WB_DW`: writeback line. Word k is bits [`WB_DW`*(k+1)-1 : `WB_DW`*k].
- `rsp_valid_o`, out, 1: one-cycle response pulse. No backpressure.
- `rsp_rdata_o`, out, `LINE_WORDS`*`WB_DW`: line buffer contents.
- `rsp_err_o`, out, 1: the request was aborted. Qualified by `rsp_valid_o`.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o`, out, 1: bus cycle, strobe, write enable.
- `wb_adr_o`, out, `WB_AW`: beat address.
- `wb_dat_o`, out, `WB_DW`: beat write data.
- `wb_sel_o`, out, `WB_SL`: byte selects. Always all ones.
- `wb_stall_i`, `wb_ack_i`, `wb_err_i`, in, 1: slave stall, ack, error.
- `wb_dat_i`, in, `WB_DW`: slave read data.

## Operation
The block has three states: IDLE, BUS and RESP.

- **IDLE**
  - `req_ready_o` = 1.
  - On `req_valid_i` & `req_ready_o`, latch the base address, `we` and `wdata` into the line buffer.
  - Clear the issue count `icnt`, the ack count `acnt` and the error flag; go to BUS.
- **BUS**
  - `wb_cyc_o` = 1.
  - `wb_stb_o` = (`icnt` < `LINE_WORDS`).
  - `wb_adr_o` = base + `icnt`.
  - `wb_dat_o` = line word `icnt`.
  - A beat is issued on `wb_stb_o` & !`wb_stall_i`; `icnt` then increments.
  - While stalled, `stb`, `adr`, `dat` and `we` stay stable.
  - On each `wb_ack_i`: in a refill, write `wb_dat_i` into line word `acnt`; in both cases `acnt` increments.
  - When `acnt` reaches `LINE_WORDS` (that is, on the last ack), go to RESP.
  - On `wb_err_i`: set the error flag and go to RESP immediately. `cyc` drops, and outstanding acks are discarded.
  - `wb_ack_i` and `wb_err_i` seen while `wb_cyc_o` = 0 are ignored.
- **RESP**
  - `wb_cyc_o` = 0 and `rsp_valid_o` = 1 for exactly one cycle.
  - `rsp_rdata_o` = line buffer: the refill data, or for a writeback the unchanged write data.
  - `rsp_err_o` = error flag.
  - Next state is IDLE.
- **Counter widths:** `icnt` and `acnt` are log2(`LINE_WORDS`)+1 bits wide. Address arithmetic is modulo 2^`WB_AW`, but aligned lines never wrap inside a line.
- **Simultaneous events:**
  - An ack and an issue in the same cycle both take effect.
  - If `ack` and `err` arrive in the same cycle, `err` wins and the line data is not updated.

## Timing
- **Reset:** while `rst_ni` = 0, the block is asynchronously forced to IDLE.
  - `req_ready_o` = 1.
  - All other outputs = 0: `wb_cyc_o`, `wb_stb_o`, `wb_we_o`, `wb_adr_o`, `wb_dat_o`, `rsp_valid_o`, `rsp_rdata_o`, `rsp_err_o`.
  - `wb_sel_o` = all ones.
  - Asserting reset mid-transfer drops `cyc` immediately; the request is lost and no response is produced.
- **All outputs are registered or decoded from state.** There is no combinational path from `wb_*_i` to `wb_*_o`.
- **Against a zero-wait slave** (`wb_mem`: ack one cycle after stb, never stalls):
  - The accepting edge is E0; beats issue at edges E1 through E`LINE_WORDS`.
  - The last ack is sampled at edge E(`LINE_WORDS`+1).
  - `rsp_valid_o` is high in the following cycle.
  - `req_ready_o` returns one cycle later.
- **Stalls:** each stalled cycle adds one cycle of latency.
- **Back-to-back requests:** successive requests are separated by at least the RESP and IDLE cycles.

## Configuration
- **`WB_TIMEOUT_EN` defined:** a watchdog counter runs in BUS.
  - It clears on each issued beat and on each ack.
  - It increments otherwise.
  - When it reaches `TIMEOUT`, it sets the error flag and forces RESP, with the same handling as `wb_err_i`.
- **`WB_TIMEOUT_EN` undefined:** the counter is absent, and BUS waits indefinitely for acks or `err`.

## Test plan
- **Refill read:** `wb_mem` preloaded with 0x11, 0x22, 0x33, 0x44 at words 0x40 to 0x43; request refill at `req_adr_i` = 0x42 -> beats to 0x40 to 0x43, `rsp_rdata_o` = {0x44, 0x33, 0x22, 0x11}, `rsp_err_o` = 0, `rsp_valid_o` in the cycle after E5.
- **Writeback then refill:** writeback {0xD, 0xC, 0xB, 0xA} to 0x80, then refill 0x80 -> `wb_sel_o` = 0xF on all beats, and the read returns the same line.
- **Stall:** slave stalls 3 cycles on beat 1 -> `wb_adr_o` holds 0x41 stable during the stall, the response arrives 3 cycles later, and the data is correct.
- **Bus error:** `wb_err_i` on the 2nd ack -> `wb_cyc_o` falls the next cycle, then `rsp_valid_o` = 1 with `rsp_err_o` = 1, then `req_ready_o` = 1.
- **Timeout:** with `WB_TIMEOUT_EN` and `TIMEOUT` = 8, slave never acks -> `rsp_err_o` = 1 after 8 idle cycles. Without the macro, the block stays in BUS.
- **Reset mid-transfer:** `rst_ni` pulled low after beat 2 -> `wb_cyc_o` = 0 asynchronously, no `rsp_valid_o`, and the next request completes normally.

Source files
------------

// File: rtl/wb_line_master.sv
// Pipelined Wishbone B4 master that moves one cache line per request as LINE_WORDS single-word beats.
// Optional watchdog enabled by defining WB_TIMEOUT_EN.
module wb_line_master #(
  parameter int unsigned WB_AW      = 12,
  parameter int unsigned WB_DW      = 32,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic                        req_we_i,
  input  logic [WB_AW-1:0]            req_adr_i,
  input  logic [LINE_WORDS*WB_DW-1:0] req_wdata_i,
  output logic                        rsp_valid_o,
  output logic [LINE_WORDS*WB_DW-1:0] rsp_rdata_o,
  output logic                        rsp_err_o,
  output logic                        wb_cyc_o,
  output logic                        wb_stb_o,
  output logic                        wb_we_o,
  output logic [WB_AW-1:0]            wb_adr_o,
  output logic [WB_DW-1:0]            wb_dat_o,
  output logic [WB_DW/8-1:0]          wb_sel_o,
  input  logic                        wb_stall_i,
  input  logic                        wb_ack_i,
  input  logic                        wb_err_i,
  input  logic [WB_DW-1:0]            wb_dat_i
);

  localparam int unsigned IW = $clog2(LINE_WORDS);
  localparam int unsigned CW = IW + 1;
  localparam logic [WB_AW-1:0] LINE_MASK = WB_AW'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                          state_q, state_d;
  logic [WB_AW-1:0]                base_q;
  logic                            we_q;
  logic [LINE_WORDS-1:0][WB_DW-1:0] line_q;
  logic [CW-1:0]                   icnt_q;
  logic [CW-1:0]                   acnt_q;
  logic                            err_q;

  logic in_bus;
  logic issue;
  logic ack_in;
  logic timeout;
  logic abort;

  assign in_bus = (state_q == S_BUS);
  assign issue  = in_bus && (icnt_q < CW'(LINE_WORDS)) && !wb_stall_i;
  assign ack_in = in_bus && wb_ack_i;
  assign abort  = in_bus && (wb_err_i || timeout);

`ifdef WB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wdog_q;

  assign timeout = in_bus && (wdog_q == TW'(TIMEOUT));

  // Watchdog: counts BUS cycles with neither an issued beat nor an ack.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wdog_q <= '0;
    end else if (!in_bus || issue || wb_ack_i) begin
      wdog_q <= '0;
    end else if (!timeout) begin
      wdog_q <= wdog_q + TW'(1);
    end
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
  assign timeout        = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and state-decoded bus/handshake outputs
  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    wb_cyc_o    = 1'b0;
    wb_stb_o    = 1'b0;
    wb_we_o     = 1'b0;
    wb_adr_o    = '0;
    wb_dat_o    = '0;
    case (state_q)
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          state_d = S_BUS;
        end
      end
      S_BUS: begin
        wb_cyc_o = 1'b1;
        wb_we_o  = we_q;
        wb_adr_o = base_q + WB_AW'(icnt_q);
        if (icnt_q < CW'(LINE_WORDS)) begin
          wb_stb_o = 1'b1;
          wb_dat_o = line_q[icnt_q[IW-1:0]];
        end
        if (abort) begin
          state_d = S_RESP;
        end else if (wb_ack_i && (acnt_q == CW'(LINE_WORDS - 1))) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid_o = 1'b1;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Line buffer, beat counters and error flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      base_q <= '0;
      we_q   <= 1'b0;
      line_q <= '0;
      icnt_q <= '0;
      acnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            base_q <= req_adr_i & ~LINE_MASK;
            we_q   <= req_we_i;
            line_q <= req_wdata_i;
            icnt_q <= '0;
            acnt_q <= '0;
            err_q  <= 1'b0;
          end
        end
        S_BUS: begin
          if (issue) begin
            icnt_q <= icnt_q + CW'(1);
          end
          // An error in the same cycle as an ack wins and leaves the line untouched.
          if (abort) begin
            err_q <= 1'b1;
          end else if (ack_in) begin
            acnt_q <= acnt_q + CW'(1);
            if (!we_q) begin
              line_q[acnt_q[IW-1:0]] <= wb_dat_i;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_rdata_o = line_q;
  assign rsp_err_o   = err_q;
  assign wb_sel_o    = '1;

endmodule

// File: tb/tb_wb_line_master.sv
// Directed and randomized bench for wb_line_master against a zero-wait memory slave and a line-level model.
module tb_wb_line_master;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 4;
  localparam int unsigned LB = LW * DW;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_adr;
  logic [LB-1:0] req_wdata;
  logic          rsp_valid;
  logic [LB-1:0] rsp_rdata;
  logic          rsp_err;
  logic          wb_cyc, wb_stb, wb_we;
  logic [AW-1:0] wb_adr;
  logic [DW-1:0] wb_dat_m;
  logic [3:0]    wb_sel;
  logic          wb_stall, wb_ack, wb_err;
  logic [DW-1:0] wb_rdat;

  wb_line_master #(
    .WB_AW(AW), .WB_DW(DW), .LINE_WORDS(LW), .TIMEOUT(8)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_adr_i(req_adr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we), .wb_adr_o(wb_adr),
    .wb_dat_o(wb_dat_m), .wb_sel_o(wb_sel),
    .wb_stall_i(wb_stall), .wb_ack_i(wb_ack), .wb_err_i(wb_err), .wb_dat_i(wb_rdat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Slave memory, and the reference model's own view of memory
  logic [DW-1:0] mem     [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  int  stall_beat = -1, stall_left = 0, err_ack = -1;
  bit  err_with_ack = 0, no_ack = 0, rand_stall = 0;
  int  beat_idx = 0, ack_idx = 0, stall_cycles = 0, sel_bad = 0;
  logic [AW-1:0] beat_adrs[$];
  logic [AW-1:0] stall_adrs[$];
  bit            pend = 0;
  logic [AW-1:0] pend_adr;
  logic [DW-1:0] pend_dat;
  logic          pend_we;

  // Zero-wait slave: acts at negedge, acks the beat accepted at the previous posedge
  always @(negedge clk) begin
    wb_ack = 1'b0;
    wb_err = 1'b0;
    if (!rst_n) pend = 0;
    if (pend) begin
      pend = 0;
      if (pend_we) mem[pend_adr] = pend_dat;
      else         wb_rdat = mem[pend_adr];
      if (!no_ack) begin
        if (ack_idx == err_ack) begin
          wb_err = 1'b1;
          wb_ack = err_with_ack;
        end else begin
          wb_ack = 1'b1;
        end
        ack_idx++;
      end
    end
    wb_stall = 1'b0;
    if (rst_n && wb_cyc && wb_stb) begin
      if (beat_idx == stall_beat && stall_left > 0) begin
        wb_stall = 1'b1;
        stall_left--;
      end else if (rand_stall && $urandom_range(0, 2) == 0) begin
        wb_stall = 1'b1;
      end
      if (wb_stall) begin
        stall_cycles++;
        stall_adrs.push_back(wb_adr);
      end else begin
        pend     = 1;
        pend_adr = wb_adr;
        pend_dat = wb_dat_m;
        pend_we  = wb_we;
        beat_idx++;
        beat_adrs.push_back(wb_adr);
        if (wb_sel !== 4'hF) sel_bad++;
      end
    end
  end

  task automatic check(input string tag, input logic [LB-1:0] obs, input logic [LB-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
    return a & ~AW'(LW - 1);
  endfunction

  // Expected line after an abort on ack j: words before j were refilled, the rest keep the request data
  function automatic logic [LB-1:0] model_line(input logic [AW-1:0] a, input logic [LB-1:0] wd, input int j);
    logic [LB-1:0] r;
    logic [AW-1:0] b;
    r = wd;
    b = align(a);
    for (int k = 0; k < LW; k++)
      if (k < j) r[k*DW +: DW] = ref_mem[AW'(b + AW'(k))];
    return r;
  endfunction

  task automatic do_req(input bit we, input logic [AW-1:0] adr, input logic [LB-1:0] wd, input int budget,
                        output logic [LB-1:0] rd, output bit er, output int lat, output bit got);
    beat_idx = 0; ack_idx = 0; stall_cycles = 0;
    beat_adrs.delete(); stall_adrs.delete();
    check("ready_before_req", req_ready, 1'b1);
    req_valid = 1'b1; req_we = we; req_adr = adr; req_wdata = wd;
    tick();
    req_valid = 1'b0;
    got = 0; lat = 0; rd = '0; er = 0;
    for (int i = 0; i < budget && !got; i++) begin
      tick();
      lat++;
      if (rsp_valid) begin
        got = 1; rd = rsp_rdata; er = rsp_err;
      end
    end
    if (we && got && !er)
      for (int k = 0; k < LW; k++) ref_mem[AW'(align(adr) + AW'(k))] = wd[k*DW +: DW];
  endtask

  logic [LB-1:0] rd, wd;
  bit            er, got, seen;
  int            lat;
  logic [AW-1:0] a;
  bit            we;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_adr = '0; req_wdata = '0;
    wb_stall = 1'b0; wb_ack = 1'b0; wb_err = 1'b0; wb_rdat = '0;
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    for (int k = 0; k < LW; k++) begin
      mem[12'h40 + k] = DW'(32'h11 * (k + 1));
      ref_mem[12'h40 + k] = mem[12'h40 + k];
    end
    tick(); tick();
    check("rst_ready", req_ready, 1'b1);
    check("rst_cyc", wb_cyc, 1'b0);
    check("rst_stb", wb_stb, 1'b0);
    check("rst_we", wb_we, 1'b0);
    check("rst_adr", wb_adr, '0);
    check("rst_dat", wb_dat_m, '0);
    check("rst_sel", wb_sel, 4'hF);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rdata", rsp_rdata, '0);
    check("rst_err", rsp_err, 1'b0);
    rst_n = 1'b1;
    tick();

    // Refill from an unaligned address
    do_req(0, 12'h042, '0, 60, rd, er, lat, got);
    check("refill_got", got, 1'b1);
    check("refill_data", rd, 128'h00000044_00000033_00000022_00000011);
    check("refill_err", er, 1'b0);
    check("refill_latency", lat, LW + 1);
    check("refill_nbeats", beat_adrs.size(), LW);
    for (int k = 0; k < LW; k++) check("refill_beat_adr", beat_adrs[k], 12'h040 + k);
    tick();
    check("refill_rsp_one_cycle", rsp_valid, 1'b0);
    check("refill_ready_back", req_ready, 1'b1);

    // Writeback then refill of the same line
    wd = 128'h0000000D_0000000C_0000000B_0000000A;
    do_req(1, 12'h080, wd, 60, rd, er, lat, got);
    check("wb_data", rd, wd);
    check("wb_err", er, 1'b0);
    check("wb_latency", lat, LW + 1);
    tick();
    do_req(0, 12'h080, '0, 60, rd, er, lat, got);
    check("wb_readback", rd, wd);
    check("sel_all_beats", sel_bad, 0);
    tick();

    // Three stall cycles on beat 1
    stall_beat = 1; stall_left = 3;
    do_req(0, 12'h040, '0, 60, rd, er, lat, got);
    stall_beat = -1;
    check("stall_data", rd, model_line(12'h040, '0, LW));
    check("stall_latency", lat, LW + 1 + 3);
    check("stall_count", stall_adrs.size(), 3);
    for (int k = 0; k < stall_adrs.size(); k++) check("stall_adr_hold", stall_adrs[k], 12'h041);
    tick();

    // Error on the 2nd ack
    wd = {$urandom, $urandom, $urandom, $urandom};
    err_ack = 1; err_with_ack = 0;
    do_req(0, 12'h044, wd, 60, rd, er, lat, got);
    check("err_rsp_err", er, 1'b1);
    check("err_latency", lat, 3);
    check("err_cyc_dropped", wb_cyc, 1'b0);
    check("err_data", rd, model_line(12'h044, wd, 1));
    tick();
    check("err_ready_back", req_ready, 1'b1);

    // Error and ack together on the 3rd ack: that word is not written
    wd = {$urandom, $urandom, $urandom, $urandom};
    err_ack = 2; err_with_ack = 1;
    do_req(0, 12'h048, wd, 60, rd, er, lat, got);
    err_ack = -1; err_with_ack = 0;
    check("errack_err", er, 1'b1);
    check("errack_latency", lat, 4);
    check("errack_data", rd, model_line(12'h048, wd, 2));
    tick();

    // Slave that never acks
    no_ack = 1;
    do_req(0, 12'h100, '0, 40, rd, er, lat, got);
`ifdef WB_TIMEOUT_EN
    check("timeout_got", got, 1'b1);
    check("timeout_err", er, 1'b1);
`else
    check("hang_no_rsp", got, 1'b0);
    check("hang_cyc", wb_cyc, 1'b1);
`endif
    no_ack = 0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Reset after beat 2 drops the cycle at once and loses the request
    beat_idx = 0; ack_idx = 0;
    req_valid = 1'b1; req_we = 1'b0; req_adr = 12'h040; req_wdata = '0;
    tick();
    req_valid = 1'b0;
    tick(); tick();
    check("midrst_in_bus", wb_cyc, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_cyc_async", wb_cyc, 1'b0);
    check("midrst_stb_async", wb_stb, 1'b0);
    check("midrst_ready", req_ready, 1'b1);
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (rsp_valid) seen = 1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rsp_valid) seen = 1;
    end
    check("midrst_no_rsp", seen, 1'b0);
    check("midrst_rdata_clr", rsp_rdata, '0);
    do_req(0, 12'h042, '0, 60, rd, er, lat, got);
    check("postrst_data", rd, 128'h00000044_00000033_00000022_00000011);
    check("postrst_latency", lat, LW + 1);
    tick();

    // Random traffic with random stalls
    rand_stall = 1;
    for (int t = 0; t < 24; t++) begin
      we = $urandom_range(0, 1) == 1;
      a  = AW'($urandom_range(0, (1 << AW) - 1));
      wd = {$urandom, $urandom, $urandom, $urandom};
      do_req(we, a, wd, 200, rd, er, lat, got);
      check("rand_data", rd, we ? wd : model_line(a, wd, LW));
      check("rand_err", er, 1'b0);
      check("rand_latency", lat, LW + 1 + stall_cycles);
      tick();
    end
    rand_stall = 0;
    check("sel_final", sel_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
